// File: rtl/m68k_bus_pkg.sv
// Shared types and defaults for the 68000 bus-cycle responders.
package m68k_bus_pkg;

  // Responder FSM states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COUNT,
    ST_DRAM,
    ST_NOSEL,
    ST_ACK,
    ST_BERR
  } state_t;

  // Index of the decoder select that claimed the current cycle.
  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_ROM,
    SEL_RAM,
    SEL_IO,
    SEL_CAN,
    SEL_DRAM
  } sel_t;

  // Default wait states and timeout.
  localparam int unsigned DEF_ROM_WAIT = 0;
  localparam int unsigned DEF_RAM_WAIT = 1;
  localparam int unsigned DEF_IO_WAIT  = 2;
  localparam int unsigned DEF_CAN_WAIT = 4;
  localparam int unsigned DEF_TIMEOUT  = 255;
  localparam int unsigned DEF_CNT_W    = 8;

  // Fixed select priority: ROM > RAM > IO > CAN > DRAM.
  function automatic sel_t select_index(input logic rom, input logic ram,
                                        input logic io, input logic can,
                                        input logic dram);
    if (rom)       return SEL_ROM;
    else if (ram)  return SEL_RAM;
    else if (io)   return SEL_IO;
    else if (can)  return SEL_CAN;
    else if (dram) return SEL_DRAM;
    else           return SEL_NONE;
  endfunction

endpackage

// File: rtl/bus_timeout_counter.sv
// Saturating cycle counter with clear/enable and a TIMEOUT compare flag.
// Shared by the bus, DMA and graphics responders.
module bus_timeout_counter #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CNT_W-1:0] count;

  // Count enabled edges, stopping at TIMEOUT so the value never wraps.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (rst || clear)
      count <= '0;
    else if (enable && (count != CNT_W'(TIMEOUT)))
      count <= count + 1'b1;
  end

  assign expired = (count == CNT_W'(TIMEOUT));

endmodule

// File: rtl/m68k_bus_responder.sv
// 68000 DTACK/BERR generator: per-region wait states, DRAM acknowledge
// pass-through and a bus-error timeout for unterminated cycles.
module m68k_bus_responder
  import m68k_bus_pkg::*;
#(
  parameter int unsigned ROM_WAIT = DEF_ROM_WAIT,
  parameter int unsigned RAM_WAIT = DEF_RAM_WAIT,
  parameter int unsigned IO_WAIT  = DEF_IO_WAIT,
  parameter int unsigned CAN_WAIT = DEF_CAN_WAIT,
  parameter int unsigned TIMEOUT  = DEF_TIMEOUT,
  parameter int unsigned CNT_W    = DEF_CNT_W
) (
  input  logic Clock,
  input  logic Reset_H,
  input  logic AS_L,
  input  logic UDS_L,
  input  logic LDS_L,
  input  logic WE_L,
  input  logic OnChipRomSelect_H,
  input  logic OnChipRamSelect_H,
  input  logic IOSelect_H,
  input  logic CanBusSelect_H,
  input  logic DramSelect_H,
  input  logic DramDtack_L,
  output logic Dtack_L,
  output logic Berr_L,
  output logic CycleWrite_H
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  sel_t             start_sel;
  logic             start;
  logic             timeout_hit;
  logic             tcnt_clear;
  logic             tcnt_en;

  // Wait-state load value for the claiming region.
  function automatic logic [CNT_W-1:0] wait_for(input sel_t s);
    case (s)
      SEL_ROM: return CNT_W'(ROM_WAIT);
      SEL_RAM: return CNT_W'(RAM_WAIT);
      SEL_IO:  return CNT_W'(IO_WAIT);
      SEL_CAN: return CNT_W'(CAN_WAIT);
      default: return '0;
    endcase
  endfunction

  assign start     = !AS_L && !(UDS_L && LDS_L);
  assign start_sel = select_index(OnChipRomSelect_H, OnChipRamSelect_H,
                                  IOSelect_H, CanBusSelect_H, DramSelect_H);

  // Timeout runs only while a cycle is waiting for its terminator.
  assign tcnt_clear = (state == ST_IDLE);
  assign tcnt_en    = (state == ST_COUNT) || (state == ST_DRAM) ||
                      (state == ST_NOSEL);

  bus_timeout_counter #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timeout (
    .clk     (Clock),
    .rst     (Reset_H),
    .clear   (tcnt_clear),
    .enable  (tcnt_en),
    .expired (timeout_hit)
  );

  // Cycle FSM with registered Dtack_L / Berr_L / CycleWrite_H.
  // Every path that drives one output low keeps the other high.
  always_ff @(posedge Clock) begin
    if (Reset_H) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      Dtack_L      <= 1'b1;
      Berr_L       <= 1'b1;
      CycleWrite_H <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          Dtack_L <= 1'b1;
          Berr_L  <= 1'b1;
          if (start) begin
            // The select is captured here; later decoder changes are ignored.
            CycleWrite_H <= !WE_L;
            cnt          <= wait_for(start_sel);
            case (start_sel)
              SEL_NONE: state <= ST_NOSEL;
              SEL_DRAM: state <= ST_DRAM;
              default:  state <= ST_COUNT;
            endcase
          end
        end

        ST_COUNT: begin
          if (AS_L) begin
            state   <= ST_IDLE;
            Dtack_L <= 1'b1;
            Berr_L  <= 1'b1;
          end else if (cnt == '0) begin
            state   <= ST_ACK;
            Dtack_L <= 1'b0;
          end else if (timeout_hit) begin
            state  <= ST_BERR;
            Berr_L <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        ST_DRAM: begin
          if (AS_L) begin
            state   <= ST_IDLE;
            Dtack_L <= 1'b1;
            Berr_L  <= 1'b1;
          end else begin
            Dtack_L <= DramDtack_L;
            if (!DramDtack_L) begin
              state <= ST_ACK;
            end else if (timeout_hit) begin
              state  <= ST_BERR;
              Berr_L <= 1'b0;
            end
          end
        end

        ST_NOSEL: begin
          if (AS_L) begin
            state   <= ST_IDLE;
            Dtack_L <= 1'b1;
            Berr_L  <= 1'b1;
          end else if (timeout_hit) begin
            state  <= ST_BERR;
            Berr_L <= 1'b0;
          end
        end

        ST_ACK: begin
          if (AS_L) begin
            state   <= ST_IDLE;
            Dtack_L <= 1'b1;
          end
        end

        ST_BERR: begin
          if (AS_L) begin
            state  <= ST_IDLE;
            Berr_L <= 1'b1;
          end
        end

        default: begin
          state   <= ST_IDLE;
          Dtack_L <= 1'b1;
          Berr_L  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_m68k_bus_responder.sv
// Directed bench for m68k_bus_responder. Inputs change 1 ns after a rising
// edge; outputs are checked 1 ns after the edge that should have produced them.
module tb_m68k_bus_responder;

  localparam int unsigned TIMEOUT = 255;

  logic Clock = 1'b0;
  logic Reset_H;
  logic AS_L, UDS_L, LDS_L, WE_L;
  logic OnChipRomSelect_H, OnChipRamSelect_H, IOSelect_H;
  logic CanBusSelect_H, DramSelect_H, DramDtack_L;
  logic Dtack_L, Berr_L, CycleWrite_H;

  int checks   = 0;
  int failures = 0;

  always #5 Clock = ~Clock;

  m68k_bus_responder #(
    .ROM_WAIT (0),
    .RAM_WAIT (3),
    .IO_WAIT  (2),
    .CAN_WAIT (4),
    .TIMEOUT  (TIMEOUT),
    .CNT_W    (8)
  ) dut (
    .Clock             (Clock),
    .Reset_H           (Reset_H),
    .AS_L              (AS_L),
    .UDS_L             (UDS_L),
    .LDS_L             (LDS_L),
    .WE_L              (WE_L),
    .OnChipRomSelect_H (OnChipRomSelect_H),
    .OnChipRamSelect_H (OnChipRamSelect_H),
    .IOSelect_H        (IOSelect_H),
    .CanBusSelect_H    (CanBusSelect_H),
    .DramSelect_H      (DramSelect_H),
    .DramDtack_L       (DramDtack_L),
    .Dtack_L           (Dtack_L),
    .Berr_L            (Berr_L),
    .CycleWrite_H      (CycleWrite_H)
  );

  task automatic check(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time);
    end
  endtask

  // Advance n rising edges, then settle 1 ns.
  task automatic step(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic bus_idle();
    AS_L = 1'b1; UDS_L = 1'b1; LDS_L = 1'b1; WE_L = 1'b1;
    OnChipRomSelect_H = 1'b0; OnChipRamSelect_H = 1'b0; IOSelect_H = 1'b0;
    CanBusSelect_H = 1'b0; DramSelect_H = 1'b0; DramDtack_L = 1'b1;
  endtask

  task automatic start_cycle(input logic rom, input logic ram, input logic io,
                             input logic can, input logic dram, input logic we_l);
    OnChipRomSelect_H = rom; OnChipRamSelect_H = ram; IOSelect_H = io;
    CanBusSelect_H = can; DramSelect_H = dram; WE_L = we_l;
    AS_L = 1'b0; UDS_L = 1'b0; LDS_L = 1'b0;
  endtask

  // Dtack_L and Berr_L must never be low together.
  always @(negedge Clock) check("never_both_low", Dtack_L | Berr_L, 1'b1);

  initial begin
    // Reset state
    Reset_H = 1'b1;
    bus_idle();
    step(2);
    check("rst_dtack", Dtack_L, 1'b1);
    check("rst_berr", Berr_L, 1'b1);
    check("rst_cwrite", CycleWrite_H, 1'b0);
    Reset_H = 1'b0;
    step(2);
    check("idle_dtack", Dtack_L, 1'b1);

    // ROM read, zero wait: start at N, Dtack_L low after N+1
    start_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1);
    check("rom_n0_dtack", Dtack_L, 1'b1);
    check("rom_cwrite", CycleWrite_H, 1'b0);
    step(1);
    check("rom_n1_dtack", Dtack_L, 1'b0);
    check("rom_n1_berr", Berr_L, 1'b1);
    step(2);
    check("rom_hold_dtack", Dtack_L, 1'b0);
    AS_L = 1'b1;
    step(1);
    check("rom_release_dtack", Dtack_L, 1'b1);
    bus_idle();
    step(1);

    // IO write, two waits: data strobes late, count from the strobe edge
    start_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    UDS_L = 1'b1; LDS_L = 1'b1;
    step(2);
    check("io_no_start_dtack", Dtack_L, 1'b1);
    UDS_L = 1'b0; LDS_L = 1'b0;
    step(1);
    check("io_n0_cwrite", CycleWrite_H, 1'b1);
    step(2);
    check("io_n2_dtack", Dtack_L, 1'b1);
    check("io_n2_cwrite", CycleWrite_H, 1'b1);
    step(1);
    check("io_n3_dtack", Dtack_L, 1'b0);
    check("io_n3_cwrite", CycleWrite_H, 1'b1);
    AS_L = 1'b1;
    step(1);
    check("io_release_dtack", Dtack_L, 1'b1);
    bus_idle();
    step(1);

    // DRAM: Dtack_L follows DramDtack_L one edge later, then held
    start_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(4);
    check("dram_wait_dtack", Dtack_L, 1'b1);
    DramDtack_L = 1'b0;
    step(1);
    check("dram_ack_dtack", Dtack_L, 1'b0);
    DramDtack_L = 1'b1;
    step(2);
    check("dram_hold_dtack", Dtack_L, 1'b0);
    AS_L = 1'b1;
    step(1);
    check("dram_release_dtack", Dtack_L, 1'b1);
    bus_idle();
    step(1);

    // Unmapped: tcnt reaches TIMEOUT at N+TIMEOUT, Berr_L low after N+TIMEOUT+1
    start_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1);
    step(TIMEOUT);
    check("nosel_pre_berr", Berr_L, 1'b1);
    step(1);
    check("nosel_berr", Berr_L, 1'b0);
    check("nosel_dtack", Dtack_L, 1'b1);
    step(3);
    check("nosel_hold_berr", Berr_L, 1'b0);
    AS_L = 1'b1;
    step(1);
    check("nosel_release_berr", Berr_L, 1'b1);
    bus_idle();
    step(1);

    // Abort: RAM with 3 waits, AS_L raised after one wait -> no Dtack_L
    start_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(2);
    AS_L = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("abort_dtack", Dtack_L, 1'b1);
    end
    bus_idle();
    step(1);

    // Reset while in ACK with AS_L still low
    start_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(2);
    check("rstack_pre_dtack", Dtack_L, 1'b0);
    Reset_H = 1'b1;
    step(1);
    check("rstack_dtack", Dtack_L, 1'b1);
    check("rstack_cwrite", CycleWrite_H, 1'b0);
    Reset_H = 1'b0;
    bus_idle();
    step(1);
    check("rstack_idle_dtack", Dtack_L, 1'b1);

    // Priority: ROM and RAM both asserted -> ROM timing (Dtack_L after N+1)
    start_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(2);
    check("prio_dtack", Dtack_L, 1'b0);
    AS_L = 1'b1;
    step(1);
    bus_idle();
    step(1);

    // Latched select: CAN (4 waits) start, decoder switches to ROM mid-cycle
    start_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1);
    CanBusSelect_H = 1'b0;
    OnChipRomSelect_H = 1'b1;
    step(4);
    check("latch_n4_dtack", Dtack_L, 1'b1);
    step(1);
    check("latch_n5_dtack", Dtack_L, 1'b0);
    AS_L = 1'b1;
    step(1);
    check("latch_release_dtack", Dtack_L, 1'b1);
    bus_idle();
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
